// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: one shared shift/add-subtract
// datapath, one iteration per cycle, stalls the execute stage until done.
module muldiv_seq #(
  parameter int N_BITS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_vld,
  input  logic [2:0]        req_fn,
  input  logic [N_BITS-1:0] req_op1,
  input  logic [N_BITS-1:0] req_op2,
  input  logic              kill,
  input  logic              resp_rdy,
  output logic              resp_vld,
  output logic [N_BITS-1:0] resp_data,
  output logic              stall_req
);
  localparam int CW = $clog2(N_BITS);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [2:0]        fn;
  logic              sign1, sign2;
  logic [N_BITS-1:0] hi, lo, opnd;

  // Request decode: signedness, magnitudes and the two divide short-cuts
  logic              op1_signed, op2_signed, s1, s2;
  logic              div_zero, div_ovf;
  logic [N_BITS-1:0] mag1, mag2, special;

  always_comb begin
    op1_signed = (req_fn != 3'd3) && (req_fn != 3'd5) && (req_fn != 3'd7);
    op2_signed = op1_signed && (req_fn != 3'd2);
    s1         = op1_signed && req_op1[N_BITS-1];
    s2         = op2_signed && req_op2[N_BITS-1];
    mag1       = s1 ? -req_op1 : req_op1;
    mag2       = s2 ? -req_op2 : req_op2;
    div_zero   = (req_op2 == '0);
    div_ovf    = !req_fn[0] && (req_op1 == {1'b1, {(N_BITS-1){1'b0}}}) &&
                 (req_op2 == '1);
    if (req_fn[1]) special = div_zero ? req_op1 : '0;
    else           special = div_zero ? '1 : req_op1;
  end

  // Multiply: {hi,lo} shifts right, multiplier bits consumed from lo[0].
  // Divide: {hi,lo} shifts left, quotient bits enter at lo[0].
  logic [N_BITS:0]   mul_sum, div_trial;
  logic              div_ok;
  logic [N_BITS-1:0] nxt_hi, nxt_lo, q_fix, r_fix, final_res;
  logic [2*N_BITS-1:0] prod, prod_fix;

  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    div_trial = {hi, lo[N_BITS-1]} - {1'b0, opnd};
    div_ok    = !div_trial[N_BITS];
    if (state == MUL) begin
      nxt_hi = mul_sum[N_BITS:1];
      nxt_lo = {mul_sum[0], lo[N_BITS-1:1]};
    end else begin
      nxt_hi = div_ok ? div_trial[N_BITS-1:0] : {hi[N_BITS-2:0], lo[N_BITS-1]};
      nxt_lo = {lo[N_BITS-2:0], div_ok};
    end
    prod     = {nxt_hi, nxt_lo};
    prod_fix = (sign1 ^ sign2) ? -prod : prod;
    q_fix    = (sign1 ^ sign2) ? -nxt_lo : nxt_lo;
    r_fix    = sign1 ? -nxt_hi : nxt_hi;
    if (state == MUL)
      final_res = (fn == 3'd0) ? prod_fix[N_BITS-1:0] : prod_fix[2*N_BITS-1:N_BITS];
    else
      final_res = fn[1] ? r_fix : q_fix;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      fn        <= '0;
      sign1     <= 1'b0;
      sign2     <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      opnd      <= '0;
      resp_data <= '0;
    end else if (kill) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (req_vld) begin
          fn    <= req_fn;
          sign1 <= s1;
          sign2 <= s2;
          hi    <= '0;
          lo    <= mag1;
          opnd  <= mag2;
          cnt   <= CW'(N_BITS - 1);
          if (!req_fn[2]) state <= MUL;
          else if (div_zero || div_ovf) begin
            state     <= DONE;
            resp_data <= special;
          end else state <= DIV;
        end
        MUL, DIV: begin
          hi <= nxt_hi;
          lo <= nxt_lo;
          if (cnt == '0) begin
            resp_data <= final_res;
            state     <= DONE;
          end else cnt <= cnt - 1'b1;
        end
        DONE: if (resp_rdy) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign resp_vld  = (state == DONE) && !kill;
  assign stall_req = ((state == IDLE) && req_vld && !kill) || (state == MUL) ||
                     (state == DIV) || ((state == DONE) && !resp_rdy);
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: latency, stall/valid handshake, results,
// divide special cases, kill and mid-op reset.
module tb_muldiv_seq;
  logic        clk, rst_n, req_vld, kill, resp_rdy;
  logic [2:0]  req_fn;
  logic [31:0] req_op1, req_op2, resp_data;
  logic        resp_vld, stall_req;
  int          tests, fails;

  muldiv_seq #(.N_BITS(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_fn(req_fn),
    .req_op1(req_op1), .req_op2(req_op2), .kill(kill), .resp_rdy(resp_rdy),
    .resp_vld(resp_vld), .resp_data(resp_data), .stall_req(stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present op in the current cycle, accept on the next rising edge.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    req_vld = 1'b1; req_fn = f; req_op1 = a; req_op2 = b;
    @(posedge clk); #1;
    req_vld = 1'b0;
  endtask

  // Cycles from accept edge until resp_vld seen (sampled on falling edges).
  task automatic wait_vld(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_vld && lat < 100);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    tests++;
    if (resp_vld !== 1'b0 || stall_req !== 1'b0 || resp_data !== 32'h0) begin
      fails++;
      $display("FAIL reset: vld=%b stall=%b data=%h, want 0 0 00000000", resp_vld, stall_req, resp_data);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_mul_basic;
    int bad;
    bad = 0;
    @(negedge clk);
    issue(3'd0, 32'd7, 32'hFFFFFFFD);
    tests++;
    if (stall_req !== 1'b1) begin
      fails++;
      $display("FAIL mul_stall_accept: stall=%b want 1", stall_req);
    end
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      if (stall_req !== 1'b1 || resp_vld !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL mul_busy: %0d bad cycles, want 0", bad);
    end
    @(negedge clk);
    tests++;
    if (resp_vld !== 1'b1 || resp_data !== 32'hFFFFFFEB || stall_req !== 1'b0) begin
      fails++;
      $display("FAIL mul_done: vld=%b data=%h stall=%b, want 1 ffffffeb 0", resp_vld, resp_data, stall_req);
    end
    @(negedge clk);
    tests++;
    if (resp_vld !== 1'b0 || stall_req !== 1'b0 || resp_data !== 32'hFFFFFFEB) begin
      fails++;
      $display("FAIL mul_idle: vld=%b stall=%b data=%h, want 0 0 ffffffeb", resp_vld, stall_req, resp_data);
    end
  endtask

  task automatic test_mul_high;
    logic [2:0]  fns [3] = '{3'd1, 3'd3, 3'd2};
    logic [31:0] exp [3] = '{32'h40000000, 32'h40000000, 32'hC0000000};
    int lat;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      issue(fns[i], 32'h80000000, 32'h80000000);
      wait_vld(lat);
      tests++;
      if (lat != 33 || resp_data !== exp[i]) begin
        fails++;
        $display("FAIL mul_high fn%0d: lat=%0d data=%h, want 33 %h", fns[i], lat, resp_data, exp[i]);
      end
    end
  endtask

  task automatic test_div;
    logic [2:0]  fns [6] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd7};
    logic [31:0] a   [6] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd7, 32'hFFFFFFFF};
    logic [31:0] b   [6] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFFFFFE, 32'h10};
    logic [31:0] exp [6] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFD, 32'hF};
    int lat;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      issue(fns[i], a[i], b[i]);
      wait_vld(lat);
      tests++;
      if (lat != 33 || resp_data !== exp[i]) begin
        fails++;
        $display("FAIL div%0d fn%0d: lat=%0d data=%h, want 33 %h", i, fns[i], lat, resp_data, exp[i]);
      end
    end
  endtask

  task automatic test_div_special;
    logic [2:0]  fns [5] = '{3'd4, 3'd6, 3'd4, 3'd6, 3'd5};
    logic [31:0] a   [5] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'h80000000};
    logic [31:0] b   [5] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] exp [5] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0, 32'd0};
    int lat;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      issue(fns[i], a[i], b[i]);
      wait_vld(lat);
      tests++;
      // unsigned MIN/-1 is an ordinary divide
      if (lat != ((i == 4) ? 33 : 1) || resp_data !== exp[i]) begin
        fails++;
        $display("FAIL div_special%0d: lat=%0d data=%h, want %0d %h", i, lat, resp_data, (i == 4) ? 33 : 1, exp[i]);
      end
    end
  endtask

  task automatic test_kill;
    int bad, lat;
    logic [31:0] held;
    bad = 0;
    held = resp_data;
    @(negedge clk);
    issue(3'd4, 32'd100, 32'd7);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (resp_vld !== 1'b0) bad++;
    end
    kill = 1'b1;
    #1;
    if (resp_vld !== 1'b0) bad++;
    @(posedge clk); #1;
    kill = 1'b0;
    @(negedge clk);
    tests++;
    if (bad != 0 || resp_vld !== 1'b0 || stall_req !== 1'b0 || resp_data !== held) begin
      fails++;
      $display("FAIL kill_div: bad=%0d vld=%b stall=%b data=%h, want 0 0 0 %h", bad, resp_vld, stall_req, resp_data, held);
    end
    issue(3'd0, 32'd5, 32'd6);
    wait_vld(lat);
    tests++;
    if (lat != 33 || resp_data !== 32'd30) begin
      fails++;
      $display("FAIL kill_then_mul: lat=%0d data=%h, want 33 0000001e", lat, resp_data);
    end
    // kill alongside a request in IDLE blocks acceptance
    @(negedge clk);
    kill = 1'b1; req_vld = 1'b1; req_fn = 3'd0; req_op1 = 32'd3; req_op2 = 32'd3;
    #1;
    tests++;
    if (stall_req !== 1'b0) begin
      fails++;
      $display("FAIL kill_idle_stall: stall=%b want 0", stall_req);
    end
    @(posedge clk); #1;
    kill = 1'b0; req_vld = 1'b0;
    @(negedge clk);
    tests++;
    if (stall_req !== 1'b0 || resp_vld !== 1'b0) begin
      fails++;
      $display("FAIL kill_idle_accept: stall=%b vld=%b, want 0 0", stall_req, resp_vld);
    end
  endtask

  task automatic test_hold;
    int bad, lat;
    bad = 0;
    resp_rdy = 1'b0;
    @(negedge clk);
    issue(3'd5, 32'd100, 32'd7);
    wait_vld(lat);
    for (int i = 0; i < 5; i++) begin
      if (resp_vld !== 1'b1 || stall_req !== 1'b1 || resp_data !== 32'd14) bad++;
      @(negedge clk);
    end
    tests++;
    if (lat != 33 || bad != 0) begin
      fails++;
      $display("FAIL hold: lat=%0d bad=%0d, want 33 0", lat, bad);
    end
    kill = 1'b1;
    #1;
    tests++;
    if (resp_vld !== 1'b0) begin
      fails++;
      $display("FAIL kill_done_vld: vld=%b want 0", resp_vld);
    end
    @(posedge clk); #1;
    kill = 1'b0;
    resp_rdy = 1'b1;
    @(negedge clk);
    tests++;
    if (resp_vld !== 1'b0 || stall_req !== 1'b0 || resp_data !== 32'd14) begin
      fails++;
      $display("FAIL kill_done_idle: vld=%b stall=%b data=%h, want 0 0 0000000e", resp_vld, stall_req, resp_data);
    end
  endtask

  task automatic test_back_to_back;
    int lat1, lat2;
    @(negedge clk);
    issue(3'd0, 32'd9, 32'd9);
    wait_vld(lat1);
    @(negedge clk);
    issue(3'd6, 32'd9, 32'd4);
    wait_vld(lat2);
    tests++;
    if (lat1 != 33 || lat2 != 33 || resp_data !== 32'd1) begin
      fails++;
      $display("FAIL back_to_back: lat=%0d/%0d data=%h, want 33/33 00000001", lat1, lat2, resp_data);
    end
  endtask

  task automatic test_reset_mid_op;
    int bad;
    bad = 0;
    @(negedge clk);
    issue(3'd1, 32'h12345678, 32'h9ABCDEF0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if (resp_vld !== 1'b0 || stall_req !== 1'b0 || resp_data !== 32'h0) begin
      fails++;
      $display("FAIL reset_mid_op: vld=%b stall=%b data=%h, want 0 0 00000000", resp_vld, stall_req, resp_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (resp_vld !== 1'b0 || stall_req !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL reset_no_resp: %0d bad cycles, want 0", bad);
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    rst_n = 1'b0; req_vld = 1'b0; req_fn = 3'd0; req_op1 = '0; req_op2 = '0;
    kill = 1'b0; resp_rdy = 1'b1;
    test_reset;
    test_mul_basic;
    test_mul_high;
    test_div;
    test_div_special;
    test_kill;
    test_hold;
    test_back_to_back;
    test_reset_mid_op;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Iterative RV32M multiply/divide sequencer that runs beside the execute-stage ALU and time-shares one 32-iteration shift/add-subtract datapath across all eight M-extension ops. The execute stage presents an op when a valid muldiv instruction sits in the stage. The block drives a stall request into that stage's local stall (gen_stall) until the result is ready. Squash from later stages kills an in-flight op.

Parameters:
N_BITS, 32 (from core_types_pkg), operand/result width; iteration count equals N_BITS.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_vld  in  1  muldiv op present in execute stage (stage vld && is_muldiv)
req_fn  in  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
req_op1  in  N_BITS  rs1 value (dividend / multiplicand)
req_op2  in  N_BITS  rs2 value (divisor / multiplier)
kill  in  1  squash; aborts current op
resp_rdy  in  1  execute stage can consume result (not downstream-stalled)
resp_vld  out  1  result valid this cycle
resp_data  out  N_BITS  result
stall_req  out  1  hold execute stage

Behaviour:
- One clock, reset asynchronous active-low.
- Reset values: state IDLE, counter 0, resp_data 0. resp_vld and stall_req are therefore 0 out of reset.
- States: IDLE, MUL, DIV, DONE. 5-bit counter.
- IDLE transitions:
  - req_vld && !kill: latch fn, magnitudes and sign flags; counter=N_BITS-1.
  - fn<4 goes to MUL.
  - fn>=4 with divisor==0 or (signed fn, op1==0x80000000, op2==0xFFFFFFFF) goes to DONE with the special result latched.
  - Otherwise fn>=4 goes to DIV.
- MUL/DIV: one iteration per cycle, counter decrements. At counter==0, the final sign-fixed result is latched into resp_data and the state goes to DONE.
- DONE: stays until resp_rdy, then goes to IDLE. A new request is accepted no earlier than the cycle after leaving DONE.
- kill: in any state, state goes to IDLE next edge. The counter is cleared and resp_data is unchanged. kill overrides acceptance in IDLE and overrides completion.
- Reset asserted mid-op: immediate return to reset values; no response.
- Latency:
  - Accept at edge T; iterations occupy cycles T+1..T+32; resp_vld high from cycle T+33.
  - Special divide cases: resp_vld at T+1.
- resp_vld = (state==DONE) && !kill.
- stall_req = (state==IDLE && req_vld && !kill) || state==MUL || state==DIV || (state==DONE && !resp_rdy). In DONE with resp_rdy high, stall_req=0, so the stage advances with resp_data that same cycle.
- Multiply:
  - Unsigned shift-add on magnitudes into a 2*N_BITS product.
  - Signedness: MUL/MULH treat both operands as signed; MULHSU treats op1 signed, op2 unsigned; MULHU treats both unsigned.
  - Negate the 64-bit product if sign1^sign2.
  - MUL returns low word; others return high word.
- Divide:
  - Restoring divide on magnitudes, one quotient bit per cycle.
  - Quotient sign = sign1^sign2; remainder sign = sign of dividend; applies to signed ops only.
- Special results:
  - Divide by zero: quotient 0xFFFFFFFF, remainder = op1.
  - Signed overflow: quotient 0x80000000, remainder 0.
- Operand inputs are ignored outside IDLE acceptance; the execute stage is stalled, so they are stable anyway.
- resp_data holds its last result until the next completion.

Test Plan:
- MUL 7 * 0xFFFFFFFD (-3), resp_rdy=1 -> stall_req high T..T+32, resp_vld at T+33, resp_data 0xFFFFFFEB, state IDLE at T+34.
- MULH/MULHU/MULHSU 0x80000000 * 0x80000000 -> 0x40000000 / 0x40000000 / 0xC0000000.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
- DIV 5/0 -> resp_vld at T+1, 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
- kill asserted at iteration cycle 10 of a DIV -> IDLE next cycle, resp_vld never high, stall_req low; a new MUL issued the following cycle completes normally in 33 cycles.
- resp_rdy held low 5 cycles in DONE -> resp_vld and stall_req stay high and resp_data stays stable; kill in DONE -> resp_vld drops the same cycle, IDLE next cycle.
